// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types, frame sizing and parity helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam int SHREG_W = 10;

    // Bits following the start bit: data (7/8), optional parity, one stop.
    function automatic logic [3:0] frame_bits(input logic eight, input logic pen);
        return 4'd8 + {3'b000, eight} + {3'b000, pen};
    endfunction

    // Even parity over 7 or 8 data bits, inverted for odd parity.
    function automatic logic parity(input logic [7:0] data, input logic eight,
                                    input logic ohel);
        return (^data[6:0]) ^ (eight & data[7]) ^ ohel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_synchronizer.sv
// ============================================================================
// Module   : rx_synchronizer
// Brief    : Two-flop synchronizer for the serial line plus falling-edge flop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_synchronizer (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic [2:0] r_sync;

    // All stages reset high so a line idling high produces no spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 3'b111;
        end else begin
            r_sync <= {r_sync[1:0], rx};
        end
    end

    assign rx_s = r_sync[1];
    assign fall = r_sync[2] & ~r_sync[1];

endmodule

`default_nettype wire

// File: rtl/receive_engine.sv
// ============================================================================
// Module   : receive_engine
// Brief    : UART receiver - deframes, checks parity/stop, holds byte + flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module receive_engine
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        read,
    input  logic        eight,
    input  logic        pen,
    input  logic        ohel,
    input  logic [18:0] baud_decode,
    output logic [7:0]  rx_data,
    output logic        rx_rdy,
    output logic        perr,
    output logic        ferr,
    output logic        ovf
);

    logic               w_rx_s;
    logic               w_fall;
    state_t             r_state;
    logic [18:0]        r_count;
    logic [3:0]         r_bit_cnt;
    logic [SHREG_W-1:0] r_shreg;
    logic               r_eight;
    logic               r_pen;
    logic               r_ohel;

    logic [3:0]         w_frame_n;
    logic               w_bit_tick;
    logic               w_done;
    logic [SHREG_W-1:0] w_shreg_next;
    logic [SHREG_W-1:0] w_aligned;
    logic [7:0]         w_data;
    logic               w_par_rx;
    logic               w_stop;
    logic               w_perr;

    rx_synchronizer u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (w_rx_s),
        .fall (w_fall)
    );

    assign w_frame_n    = frame_bits(r_eight, r_pen);
    assign w_bit_tick   = (r_state == DATA) && (r_count == baud_decode);
    assign w_done       = w_bit_tick && ((r_bit_cnt + 4'd1) == w_frame_n);
    assign w_shreg_next = {w_rx_s, r_shreg[SHREG_W-1:1]};

    // Bits enter at the MSB, so a short frame sits high in the register.
    assign w_aligned = w_shreg_next >> (4'd10 - w_frame_n);
    assign w_data    = {r_eight & w_aligned[7], w_aligned[6:0]};
    assign w_par_rx  = r_eight ? w_aligned[8] : w_aligned[7];
    assign w_stop    = w_aligned[w_frame_n - 4'd1];
    assign w_perr    = r_pen & (w_par_rx != parity(w_data, r_eight, r_ohel));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_eight   <= 1'b0;
            r_pen     <= 1'b0;
            r_ohel    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_count <= '0;
                    if (w_fall) begin
                        r_eight <= eight;
                        r_pen   <= pen;
                        r_ohel  <= ohel;
                        r_state <= START;
                    end
                end
                START: begin
                    if (r_count == (baud_decode >> 1)) begin
                        r_count <= '0;
                        if (!w_rx_s) begin
                            r_bit_cnt <= '0;
                            r_state   <= DATA;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_count <= r_count + 19'd1;
                    end
                end
                DATA: begin
                    if (w_bit_tick) begin
                        r_shreg   <= w_shreg_next;
                        r_count   <= '0;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (w_done) begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_count <= r_count + 19'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    // A completing byte takes priority over a simultaneous read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data <= '0;
            rx_rdy  <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (w_done) begin
                rx_data <= w_data;
                rx_rdy  <= 1'b1;
                perr    <= w_perr;
                ferr    <= ~w_stop;
            end else if (read) begin
                rx_rdy <= 1'b0;
                perr   <= 1'b0;
                ferr   <= 1'b0;
            end

            if (w_done && rx_rdy && !read) begin
                ovf <= 1'b1;
            end else if (read) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
